if_id_hazard: RTL and testbench
===============================

IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port newpc  input  32  PC+4 from fetch.
REQ-004 SHALL have port instr  input  32  fetched instruction word.
REQ-005 SHALL have port ex_memread  input  1  MemRead bit of the instruction currently in ID/EX.
REQ-006 SHALL have port ex_rt  input  5  destination rt of the instruction currently in ID/EX.
REQ-007 SHALL have port flush  input  1  branch/jump taken; squash the fetched instruction.
REQ-008 SHALL have port ext_stall  input  1  external freeze request, e.g. memory not ready.
REQ-009 SHALL have port pc_write  output  1  PC register enable.
REQ-010 SHALL have port saidaNewPC  output  32  registered PC+4.
REQ-011 SHALL have port saidaInstr  output  32  registered instruction.
REQ-012 SHALL have port valid  output  1  registered instruction is real, not a bubble.
REQ-013 SHALL have port bubble  output  1  force ID/EX control bits (9 bits) to zero this cycle.
REQ-014 SHALL have port state  output  2  FSM state: RUN=0, STALL=1, FLUSH=2.

Function
REQ-015 SHALL compute rs=saidaInstr[25:21] and rt=saidaInstr[20:16] combinationally from the registered instruction.
REQ-016 SHALL assert load-use hazard (lu) iff valid && ex_memread && ex_rt!=0 && (ex_rt==rs || ex_rt==rt).
REQ-017 SHALL drive pc_write=0 when (lu || ext_stall) && !flush, else 1.
REQ-018 SHALL drive bubble=1 when lu || flush, else 0; ext_stall alone SHALL NOT assert bubble.
REQ-019 SHALL, on a clock edge with flush=1, load saidaInstr=0x00000000, saidaNewPC=0 and valid=0; flush has priority over lu and ext_stall.
REQ-020 SHALL, on a clock edge with flush=0 and (lu || ext_stall), hold saidaInstr, saidaNewPC and valid unchanged.
REQ-021 SHALL otherwise load saidaInstr=instr, saidaNewPC=newpc and valid=1, giving 1-cycle latency from fetch to ID.
REQ-022 SHALL transition the FSM on each edge to FLUSH if flush, else to STALL if lu || ext_stall, else to RUN; FSM state is status only and SHALL NOT gate outputs.
REQ-023 SHALL NOT assert lu while valid=0, so a flushed slot never causes a stall.
REQ-024 SHALL end a load-use stall after exactly one cycle when ID/EX receives the bubble, i.e. when ex_memread becomes 0.
REQ-025 SHALL stall for as many consecutive cycles as ext_stall remains high.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set saidaInstr=0, saidaNewPC=0, valid=0 and state=RUN.
REQ-027 SHALL give reset priority over flush, lu and ext_stall, including mid-stall.
REQ-028 SHALL drive pc_write=1 and bubble=0 while reset=1, regardless of other inputs.

Configuration
REQ-029 SHALL implement a hazard statistics feature under macro IF_ID_HAZARD_STATS_EN.
REQ-030 SHALL, with IF_ID_HAZARD_STATS_EN defined, add outputs stall_cnt (16) and flush_cnt (16).
REQ-031 SHALL increment stall_cnt on each edge with pc_write=0, and flush_cnt on each edge with flush=1.
REQ-032 SHALL make both counters saturate at 0xFFFF and clear on reset.
REQ-033 SHALL, with IF_ID_HAZARD_STATS_EN undefined, omit both counter ports and all counter logic.

Verification
REQ-034 SHALL cover pass-through: instr=0x8C080004 (lw $t0,4($0)), newpc=0x4, no hazards -> next cycle saidaInstr=0x8C080004, saidaNewPC=0x4, valid=1, state=RUN.
REQ-035 SHALL cover load-use: IF/ID holds 0x01095020 (add $t2,$t0,$t1), ex_memread=1, ex_rt=8 -> pc_write=0, bubble=1; IF/ID held one cycle, state=STALL; ex_memread=0 next cycle -> pc_write=1.
REQ-036 SHALL cover the $zero exception: ex_memread=1, ex_rt=0, rs=0 -> no stall, pc_write=1, bubble=0.
REQ-037 SHALL cover flush during a hazard: lu=1 and flush=1 in the same cycle -> pc_write=1, saidaInstr=0, valid=0, state=FLUSH; following cycle lu=0.
REQ-038 SHALL cover ext_stall: held 3 cycles -> pc_write=0 and bubble=0 for 3 cycles, IF/ID unchanged; with IF_ID_HAZARD_STATS_EN defined, stall_cnt=3.
REQ-039 SHALL cover reset mid-stall: reset=1 during ext_stall -> saidaInstr=0, valid=0, state=RUN, counters=0.

Source files
------------

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection, flush and external stall.
// Optional hazard statistics counters are enabled with the IF_ID_HAZARD_STATS_EN macro.
module if_id_hazard (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] newpc,
    input  logic [31:0] instr,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        flush,
    input  logic        ext_stall,
    output logic        pc_write,
    output logic [31:0] saidaNewPC,
    output logic [31:0] saidaInstr,
    output logic        valid,
    output logic        bubble,
`ifdef IF_ID_HAZARD_STATS_EN
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`else
    output logic [1:0]  state
`endif
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [4:0]  rs, rt;
    logic        lu;
    logic        hold;

    always_comb begin
        rs   = instr_q[25:21];
        rt   = instr_q[20:16];
        // A bubble in IF/ID (valid=0) can never be the consumer of a load.
        lu   = valid_q && ex_memread && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
        hold = (lu || ext_stall) && !flush;

        pc_write = reset ? 1'b1 : !hold;
        bubble   = reset ? 1'b0 : (lu || flush);

        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        state_d = StRun;
        if (reset) begin
            instr_d = 32'd0;
            pc_d    = 32'd0;
            valid_d = 1'b0;
            state_d = StRun;
        end else if (flush) begin
            instr_d = 32'd0;
            pc_d    = 32'd0;
            valid_d = 1'b0;
            state_d = StFlush;
        end else if (hold) begin
            state_d = StStall;
        end else begin
            instr_d = instr;
            pc_d    = newpc;
            valid_d = 1'b1;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
        valid_q <= valid_d;
        state_q <= state_d;
    end

    assign saidaInstr = instr_q;
    assign saidaNewPC = pc_q;
    assign valid      = valid_q;
    assign state      = state_q;

`ifdef IF_ID_HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset) begin
            stall_cnt_d = 16'd0;
            flush_cnt_d = 16'd0;
        end else begin
            if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_hazard.sv
// Self-checking bench for if_id_hazard: directed scenarios followed by random traffic,
// compared against a behavioural model of the pipeline register and hazard rules.
module tb_if_id_hazard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] newpc = 32'd0;
    logic [31:0] instr = 32'd0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rt = 5'd0;
    logic        flush = 1'b0;
    logic        ext_stall = 1'b0;
    logic        pc_write;
    logic [31:0] saidaNewPC;
    logic [31:0] saidaInstr;
    logic        valid;
    logic        bubble;
    logic [1:0]  state;
`ifdef IF_ID_HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    if_id_hazard dut (
        .clk        (clk),
        .reset      (reset),
        .newpc      (newpc),
        .instr      (instr),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .flush      (flush),
        .ext_stall  (ext_stall),
        .pc_write   (pc_write),
        .saidaNewPC (saidaNewPC),
        .saidaInstr (saidaInstr),
        .valid      (valid),
        .bubble     (bubble),
`ifdef IF_ID_HAZARD_STATS_EN
        .state      (state),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`else
        .state      (state)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the IF/ID contents and statistics.
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    int          m_valid;
    int          m_state;
    int          m_stall_cnt;
    int          m_flush_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_lu(input int exmr, input int exrt);
        int src_s, src_t;
        src_s = int'((m_instr >> 21) % 32);
        src_t = int'((m_instr >> 16) % 32);
        return (m_valid == 1 && exmr == 1 && exrt != 0 && (exrt == src_s || exrt == src_t))
               ? 1 : 0;
    endfunction

    // Apply one cycle of inputs, check combinational outputs, clock, then check registers.
    task automatic step(input int rst, input logic [31:0] pc_in, input logic [31:0] ins,
                        input int exmr, input int exrt, input int fl, input int es);
        int lu_e, pcw_e, bub_e;
        reset      = (rst != 0);
        newpc      = pc_in;
        instr      = ins;
        ex_memread = (exmr != 0);
        ex_rt      = 5'(exrt);
        flush      = (fl != 0);
        ext_stall  = (es != 0);
        #1;
        lu_e  = model_lu(exmr, exrt);
        pcw_e = (rst != 0) ? 1 : (((lu_e == 1 || es != 0) && fl == 0) ? 0 : 1);
        bub_e = (rst != 0) ? 0 : ((lu_e == 1 || fl != 0) ? 1 : 0);
        chk("pc_write", {31'd0, pc_write}, 32'(pcw_e));
        chk("bubble", {31'd0, bubble}, 32'(bub_e));
        @(posedge clk);
        if (rst != 0) begin
            m_instr = 0; m_pc = 0; m_valid = 0; m_state = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (pcw_e == 0 && m_stall_cnt < 65535) m_stall_cnt++;
            if (fl != 0 && m_flush_cnt < 65535) m_flush_cnt++;
            if (fl != 0) begin
                m_instr = 0; m_pc = 0; m_valid = 0; m_state = 2;
            end else if (pcw_e == 0) begin
                m_state = 1;
            end else begin
                m_instr = ins; m_pc = pc_in; m_valid = 1; m_state = 0;
            end
        end
        #1;
        chk("saidaInstr", saidaInstr, m_instr);
        chk("saidaNewPC", saidaNewPC, m_pc);
        chk("valid", {31'd0, valid}, 32'(m_valid));
        chk("state", {30'd0, state}, 32'(m_state));
`ifdef IF_ID_HAZARD_STATS_EN
        chk("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall_cnt));
        chk("flush_cnt", {16'd0, flush_cnt}, 32'(m_flush_cnt));
`endif
    endtask

    initial begin
        m_instr = 0; m_pc = 0; m_valid = 0; m_state = 0;
        m_stall_cnt = 0; m_flush_cnt = 0;
        @(posedge clk);
        #1;
        // Reset
        step(1, 32'h0, 32'h0, 0, 0, 0, 0);
        step(1, 32'h10, 32'h8C080004, 1, 8, 1, 1);
        // Pass-through of lw $t0,4($0)
        step(0, 32'h4, 32'h8C080004, 0, 0, 0, 0);
        chk("pass_instr", saidaInstr, 32'h8C080004);
        // Load-use: add $t2,$t0,$t1 behind a load to $t0
        step(0, 32'h8, 32'h01095020, 0, 0, 0, 0);
        step(0, 32'hC, 32'h8C090008, 1, 8, 0, 0);
        chk("lu_state", {30'd0, state}, 32'd1);
        step(0, 32'hC, 32'h8C090008, 0, 8, 0, 0);
        // $zero exception: rs=0, load target $0
        step(0, 32'h10, 32'h00001020, 0, 0, 0, 0);
        step(0, 32'h14, 32'h00000000, 1, 0, 0, 0);
        // Flush in the same cycle as a load-use hazard
        step(0, 32'h18, 32'h01095020, 0, 0, 0, 0);
        step(0, 32'h1C, 32'h12345678, 1, 8, 1, 0);
        chk("flush_valid", {31'd0, valid}, 32'd0);
        step(0, 32'h20, 32'h01095020, 1, 8, 0, 0);
        // External stall held three cycles
        step(0, 32'h24, 32'hAC0A0010, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h28, 32'h11111111, 0, 0, 0, 1);
`ifdef IF_ID_HAZARD_STATS_EN
        step(1, 32'h0, 32'h0, 0, 0, 0, 0);
        step(0, 32'h24, 32'hAC0A0010, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h28, 32'h11111111, 0, 0, 0, 1);
        chk("stall_cnt_3", {16'd0, stall_cnt}, 32'd3);
`endif
        // Reset in the middle of an external stall
        step(0, 32'h2C, 32'h22222222, 0, 0, 0, 1);
        step(1, 32'h30, 32'h33333333, 1, 8, 0, 1);
        // Random traffic with small register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 39) == 0) ? 1 : 0, $urandom, ins,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0);
        end
`ifdef IF_ID_HAZARD_STATS_EN
        // Saturation of the stall counter
        step(1, 32'h0, 32'h0, 0, 0, 0, 0);
        reset = 1'b0;
        flush = 1'b0;
        ex_memread = 1'b0;
        ext_stall = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        ext_stall = 1'b0;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
